// File: rtl/stepper_sequencer_pkg.sv
// Shared definitions for the stepper sequencer: FSM states and the
// phase-index to coil-drive table used in both full- and half-step modes.
package stepper_sequencer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int PHASE_W = 3;

    // Entry [0] is the rightmost nibble; even phases energise a single coil.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    function automatic logic [3:0] phase_coils(input logic [PHASE_W-1:0] phase);
        return PHASE_TABLE[phase];
    endfunction

endpackage

// File: rtl/stepper_rate_timer.sv
// Loadable step-period counter: counts 0..P-1 while running and emits a
// one-cycle tick when the count sits at P-1 (P=0 is treated as 1).
module stepper_rate_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] r_per;
    logic [DIV_W-1:0] r_cnt;

    assign tick = run && (r_cnt == r_per - DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per <= DIV_W'(1);
            r_cnt <= '0;
        end else if (load) begin
            r_per <= (period == '0) ? DIV_W'(1) : period;
            r_cnt <= '0;
        end else if (run) begin
            if (tick) r_cnt <= '0;
            else      r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper motor move sequencer: latches a move on start, steps the coil phase
// at a programmable rate, tracks signed position and reports done/abort.
module stepper_sequencer
    import stepper_sequencer_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             dir,
    input  logic             half_step,
    input  logic             hold,
    input  logic [DIV_W-1:0] period,
    input  logic [CNT_W-1:0] steps,
    output logic [3:0]       coils,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] pos
);

    state_t                    r_state;
    logic                      r_dir;
    logic                      r_half;
    logic [CNT_W-1:0]          r_left;
    logic [PHASE_W-1:0]        r_phase;
    logic signed [POS_W-1:0]   r_pos;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_aborted;

    logic                      w_accept;
    logic                      w_run;
    logic                      w_tick;
    logic [1:0]                w_mag;
    logic [PHASE_W-1:0]        w_phase_step;
    logic [POS_W-1:0]          w_mag_ext;
    logic signed [POS_W-1:0]   w_pos_step;

    assign w_accept = (r_state == ST_IDLE) && start && en;
    assign w_run    = (r_state == ST_RUN);

    // Full-step from an odd phase moves by one so it lands back on a single-coil phase.
    assign w_mag        = (r_half || r_phase[0]) ? 2'd1 : 2'd2;
    assign w_phase_step = r_dir ? {1'b0, w_mag} : (3'd0 - {1'b0, w_mag});
    assign w_mag_ext    = {{(POS_W-2){1'b0}}, w_mag};
    assign w_pos_step   = r_dir ? signed'(w_mag_ext) : -signed'(w_mag_ext);

    stepper_rate_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept),
        .run    (w_run),
        .period (period),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_dir     <= 1'b0;
            r_half    <= 1'b0;
            r_left    <= '0;
            r_phase   <= '0;
            r_pos     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dir   <= dir;
                        r_half  <= half_step;
                        r_left  <= steps;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Abort outranks both the zero-length finish and a pending final step.
                    if (!en) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (r_left == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_tick) begin
                        r_phase <= r_phase + w_phase_step;
                        r_pos   <= r_pos + w_pos_step;
                        r_left  <= r_left - CNT_W'(1);
                        if (r_left == CNT_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign coils   = (r_state == ST_RUN || hold) ? phase_coils(r_phase) : 4'b0000;
    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign pos     = r_pos;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Self-checking bench for stepper_sequencer: per-move expectations are queued
// at start and compared edge by edge as the sequencer steps.
module tb_stepper_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic        half_step = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] steps = '0;
    logic [3:0]  coils;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] pos;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          at;
        logic [3:0]  coils;
        logic [15:0] pos;
        logic        busy;
        logic        done;
        logic        aborted;
    } exp_t;

    exp_t sb[$];

    stepper_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .dir       (dir),
        .half_step (half_step),
        .hold      (hold),
        .period    (period),
        .steps     (steps),
        .coils     (coils),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic push(input int at, input logic [3:0] c, input int p,
                        input logic b, input logic d, input logic a);
        exp_t e;
        e.at = at; e.coils = c; e.pos = 16'(p);
        e.busy = b; e.done = d; e.aborted = a;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        start = 1'b0;
    endtask

    task automatic do_start(input logic d, input logic h, input int p, input int n);
        @(negedge clk);
        dir = d; half_step = h; period = 16'(p); steps = 16'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Consume queued expectations over edges k0..k1 after start acceptance.
    task automatic sb_drain(input int k0, input int k1, input string name);
        exp_t e;
        for (int k = k0; k <= k1; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (sb.size() > 0 && sb[0].at == k) begin
                e = sb.pop_front();
                if ({coils, pos, busy, done, aborted} !== {e.coils, e.pos, e.busy, e.done, e.aborted}) begin
                    bad++;
                    $display("FAIL %s@+%0d got coils=%b pos=%0d busy=%b done=%b ab=%b want coils=%b pos=%0d busy=%b done=%b ab=%b",
                             name, k, coils, $signed(pos), busy, done, aborted,
                             e.coils, $signed(e.pos), e.busy, e.done, e.aborted);
                end
            end else if (done !== 1'b0 || aborted !== 1'b0) begin
                bad++;
                $display("FAIL %s@+%0d stray pulse got done=%b ab=%b want 0 0", name, k, done, aborted);
            end
        end
        while (sb.size() > 0 && sb[0].at <= k1) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s leftover expectation at +%0d not consumed", name, e.at);
        end
    endtask

    task automatic test_reset();
        hold = 1'b0;
        #1;
        total++;
        if ({coils, pos, busy, done, aborted} !== {4'b0000, 16'd0, 3'b000}) begin
            bad++;
            $display("FAIL reset_nohold got coils=%b pos=%0d busy=%b done=%b ab=%b want 0000 0 0 0 0",
                     coils, $signed(pos), busy, done, aborted);
        end
        hold = 1'b1;
        #1;
        total++;
        if (coils !== 4'b0001) begin
            bad++;
            $display("FAIL reset_hold got coils=%b want 0001", coils);
        end
        apply_reset();
    endtask

    task automatic test_full_fwd();
        apply_reset();
        hold = 1'b1;
        push(2,  4'b0001, 0, 1, 0, 0);
        push(3,  4'b0010, 2, 1, 0, 0);
        push(6,  4'b0100, 4, 1, 0, 0);
        push(9,  4'b1000, 6, 1, 0, 0);
        push(12, 4'b0001, 8, 0, 1, 0);
        do_start(1'b1, 1'b0, 3, 4);
        // Inputs changed mid-move must not disturb the latched move.
        dir = 1'b0; half_step = 1'b1; period = 16'd7; steps = 16'd1;
        sb_drain(1, 14, "full_fwd");
    endtask

    task automatic test_half_rev();
        apply_reset();
        hold = 1'b1;
        push(1, 4'b1001, -1, 1, 0, 0);
        push(2, 4'b1000, -2, 1, 0, 0);
        push(3, 4'b1100, -3, 0, 1, 0);
        do_start(1'b0, 1'b1, 1, 3);
        sb_drain(1, 4, "half_rev");
    endtask

    task automatic test_full_from_odd();
        apply_reset();
        hold = 1'b1;
        push(5, 4'b1100, 5, 0, 1, 0);
        do_start(1'b1, 1'b1, 1, 5);
        sb_drain(1, 5, "to_phase5");
        push(2, 4'b1000, 6, 1, 0, 0);
        push(4, 4'b0001, 8, 0, 1, 0);
        do_start(1'b1, 1'b0, 2, 2);
        sb_drain(1, 5, "full_odd");
    endtask

    task automatic test_abort();
        apply_reset();
        hold = 1'b0;
        push(2, 4'b0010, 2, 1, 0, 0);
        push(4, 4'b0100, 4, 1, 0, 0);
        do_start(1'b1, 1'b0, 2, 10);
        sb_drain(1, 4, "abort_run");
        @(negedge clk);
        en = 1'b0;
        push(5, 4'b0000, 4, 0, 0, 1);
        sb_drain(5, 7, "abort");
        hold = 1'b1;
        #1;
        total++;
        if (coils !== 4'b0100) begin
            bad++;
            $display("FAIL abort_phase_kept got coils=%b want 0100", coils);
        end
        // start while en is low must be ignored
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_en_low got busy=%b want 0", busy);
        end
        en = 1'b1;
        // abort on the edge of the final step wins over the step
        push(1, 4'b0100, 4, 1, 0, 0);
        do_start(1'b1, 1'b0, 2, 1);
        sb_drain(1, 1, "abort_final_run");
        @(negedge clk);
        en = 1'b0;
        push(2, 4'b0100, 4, 0, 0, 1);
        sb_drain(2, 3, "abort_final");
        en = 1'b1;
    endtask

    task automatic test_zero();
        apply_reset();
        hold = 1'b1;
        push(1, 4'b0001, 0, 0, 1, 0);
        do_start(1'b1, 1'b0, 5, 0);
        sb_drain(1, 3, "steps0");
        push(1, 4'b0011, 1, 1, 0, 0);
        push(2, 4'b0010, 2, 1, 0, 0);
        push(3, 4'b0110, 3, 0, 1, 0);
        do_start(1'b1, 1'b1, 0, 3);
        sb_drain(1, 4, "period0");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        hold = 1'b1;
        push(1, 4'b0011, 1, 1, 0, 0);
        push(2, 4'b0010, 2, 0, 1, 0);
        do_start(1'b1, 1'b1, 1, 2);
        sb_drain(1, 2, "b2b_first");
        push(1, 4'b0001, 0, 0, 1, 0);
        do_start(1'b0, 1'b0, 1, 1);
        sb_drain(1, 2, "b2b_second");
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        hold = 1'b1;
        push(3, 4'b0010, 2, 1, 0, 0);
        do_start(1'b1, 1'b0, 3, 4);
        sb_drain(1, 4, "midrun_pre");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({coils, pos, busy, done, aborted} !== {4'b0001, 16'd0, 3'b000}) begin
            bad++;
            $display("FAIL midrun_reset got coils=%b pos=%0d busy=%b done=%b ab=%b want 0001 0 0 0 0",
                     coils, $signed(pos), busy, done, aborted);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk);
                #1;
            end
            total++;
            if ({busy, done, aborted} !== 3'b000) begin
                bad++;
                $display("FAIL midrun_after got busy=%b done=%b ab=%b want 0 0 0", busy, done, aborted);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_fwd();
        test_half_rev();
        test_full_from_odd();
        test_abort();
        test_zero();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stepper_sequencer.md
STEPPER_SEQUENCER -- requirements
Module: stepper_sequencer

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, giving the width of the step-period input in clock cycles.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the step-count input.
REQ-003 The block SHALL have parameter POS_W, default 16, giving the width of the signed position output.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit, the run enable; low aborts motion.
REQ-007 The block SHALL have port start, input, 1 bit, the move request, sampled in IDLE only.
REQ-008 The block SHALL have port dir, input, 1 bit, the direction (1 = forward, phase increments), latched on start.
REQ-009 The block SHALL have port half_step, input, 1 bit, the mode (1 = half-step, 0 = full-step wave drive), latched on start.
REQ-010 The block SHALL have port hold, input, 1 bit, which keeps the coils energised in IDLE when high.
REQ-011 The block SHALL have port period, input, DIV_W bits, the clocks per step, latched on start.
REQ-012 The block SHALL have port steps, input, CNT_W bits, the number of steps to take, latched on start.
REQ-013 The block SHALL have port coils, output, 4 bits, the coil drive [D,C,B,A].
REQ-014 The block SHALL have port busy, output, 1 bit, high while in RUN.
REQ-015 The block SHALL have port done, output, 1 bit, a one-cycle pulse on normal completion.
REQ-016 The block SHALL have port aborted, output, 1 bit, a one-cycle pulse on an en-low abort.
REQ-017 The block SHALL have port pos, output, POS_W bits, the signed position in half-step units.

Function
REQ-018 A 3-bit phase index (0..7) SHALL map to coils as 0:0001 1:0011 2:0010 3:0110 4:0100 5:1100 6:1000 7:1001.
REQ-019 The FSM SHALL have states IDLE and RUN only.
REQ-020 In IDLE with start=1 and en=1, the block SHALL latch dir, half_step, period and steps, clear the timer, and go to RUN.
REQ-021 If the latched steps=0, the block SHALL return to IDLE on the next edge, pulsing done, with no phase change.
REQ-022 The latched period=0 SHALL be treated as 1.
REQ-023 In RUN the timer SHALL count 0..P-1, and a step SHALL occur on the edge where the timer equals P-1, i.e. the first step lands P edges after start acceptance and steps repeat every P edges.
REQ-024 A half-step SHALL move the phase by +/-1, modulo 8.
REQ-025 A full-step from an even phase SHALL move the phase by +/-2; from an odd phase it SHALL move by +/-1, landing on the adjacent even phase.
REQ-026 pos SHALL change by the same signed amount as the phase on every step, wrapping modulo 2^POS_W.
REQ-027 On the final step edge, the block SHALL update coils, pulse done and return to IDLE in the same edge, so busy falls with the final step.
REQ-028 With en=0 in RUN, the block SHALL go to IDLE on the next edge and pulse aborted, taking no step on that edge; phase and pos SHALL be retained.
REQ-029 If en falls on the edge the final step would occur, the abort SHALL take priority.
REQ-030 In RUN, coils SHALL equal the phase table entry.
REQ-031 In IDLE, coils SHALL equal the table entry when hold=1, and 0000 otherwise.
REQ-032 start SHALL be ignored while busy or while en=0.
REQ-033 Input changes during RUN SHALL have no effect, except en.

Reset
REQ-034 On rst, the block SHALL immediately enter IDLE with phase=0, pos=0, timer=0, busy=0, done=0 and aborted=0.
REQ-035 coils SHALL follow REQ-031 with phase 0 during reset.
REQ-036 A reset mid-move SHALL discard the move with no done or aborted pulse.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the 8-entry phase-to-coil table constant and the phase-width constant (3).
REQ-038 The block SHALL contain one sub-module, stepper_rate_timer, a loadable period counter emitting a one-cycle tick at P-1.
REQ-039 The phase table SHALL replace the previous single-coil 4-state next-state function; full-step mode SHALL reproduce its forward and reverse sequences.

Verification
REQ-040 The bench SHALL apply reset mid-run with hold=1 and check that coils=0001, pos=0 and busy=0 immediately, with no done pulse.
REQ-041 The bench SHALL check: phase 0, start with steps=4, period=3, dir=1, half_step=0 -> coils 0010, 0100, 1000, 0001 at edges +3, +6, +9, +12; done pulses at +12; pos=8.
REQ-042 The bench SHALL check: phase 0, steps=3, period=1, dir=0, half_step=1 -> phases 7, 6, 5 on consecutive edges; pos=-3; done with the third step.
REQ-043 The bench SHALL check: phase 5, full-step, dir=1, steps=2, period=2 -> phases 6 then 0; pos +3 total.
REQ-044 The bench SHALL check: en dropped after 2 of 10 steps with hold=0 -> aborted pulse, no done, coils 0000, pos retained.
REQ-045 The bench SHALL check: steps=0 or period=0 -> steps=0 gives done on the next edge with the phase unchanged; period=0 steps every edge.
